multicycle_controller: RTL

Sequencing FSM for the multi-cycle RV32I core variant. It replaces the single-cycle opcode decoder and steps the shared datapath through fetch, decode, execute, memory and write-back states: PC/IR register, register file, ALU, and one unified instruction/data memory with a ready handshake. It drives every datapath enable and mux select, and produces the 3-bit ALU op consumed by the existing ALU control decoder. It also flags illegal opcodes and memory stalls that exceed a limit.

---
 rtl/multicycle_controller_if.sv | 37 +++
 rtl/multicycle_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Control interface between the multi-cycle sequencer and the shared RV32I datapath.
// Latency: none, this is wiring only; all timing lives in the controller.
// Backpressure: the unified memory stalls the sequencer through Mem_Ready_i.
interface multicycle_controller_if;
  logic [6:0] OP_i;
  logic       Zero_i;
  logic       Mem_Ready_i;
  logic       Mem_Req_o;
  logic       Mem_Write_o;
  logic       I_or_D_o;
  logic       IR_Write_o;
  logic       PC_Write_o;
  logic       PC_Src_o;
  logic [1:0] ALU_Src_A_o;
  logic [1:0] ALU_Src_B_o;
  logic [2:0] ALU_Op_o;
  logic [1:0] Result_Src_o;
  logic       Reg_Write_o;
  logic       Error_o;
  logic [3:0] State_o;

  // Controller side: samples datapath status, drives every enable and select.
  modport slave (
    input  OP_i, Zero_i, Mem_Ready_i,
    output Mem_Req_o, Mem_Write_o, I_or_D_o, IR_Write_o, PC_Write_o, PC_Src_o,
           ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, Result_Src_o, Reg_Write_o,
           Error_o, State_o
  );

  // Datapath side.
  modport master (
    output OP_i, Zero_i, Mem_Ready_i,
    input  Mem_Req_o, Mem_Write_o, I_or_D_o, IR_Write_o, PC_Write_o, PC_Src_o,
           ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, Result_Src_o, Reg_Write_o,
           Error_o, State_o
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: fetch/decode/execute/memory/write-back control FSM.
// Latency: 3-5 cycles per instruction with zero-wait memory, +1 per memory wait cycle.
// Backpressure: holds the memory request stable until Mem_Ready_i; halts after STALL_LIMIT waits.
module multicycle_controller #(
  parameter int STALL_LIMIT = 15
) (
  input logic                    clk,
  input logic                    reset,
  multicycle_controller_if.slave bus
);

  localparam int CNT_W = $clog2(STALL_LIMIT + 1);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BEQ       = 4'd9,
    S_JAL       = 4'd10,
    S_LUI       = 4'd11,
    S_HALT      = 4'd12
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_error;
  logic             w_wait_state;
  logic             w_stall_max;

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                        (r_state == S_MEM_WRITE);
  assign w_stall_max  = (r_stall_cnt == CNT_W'(STALL_LIMIT));

  // State register, stall watchdog counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_stall_cnt <= '0;
      r_error     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // Counter restarts on every state entry, so it only measures the current request.
      if (w_next_state != r_state) begin
        r_stall_cnt <= '0;
      end else if (w_wait_state && !bus.Mem_Ready_i) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_next_state == S_HALT) begin
        r_error <= 1'b1;
      end
    end
  end

  // Next-state selection; in wait states Ready wins over the watchdog timeout.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: begin
        if (bus.Mem_Ready_i)  w_next_state = S_DECODE;
        else if (w_stall_max) w_next_state = S_HALT;
      end
      S_DECODE: begin
        case (bus.OP_i)
          7'h03, 7'h23: w_next_state = S_MEM_ADDR;
          7'h33:        w_next_state = S_EXEC_R;
          7'h13:        w_next_state = S_EXEC_I;
          7'h63:        w_next_state = S_BEQ;
          7'h6F:        w_next_state = S_JAL;
          7'h37:        w_next_state = S_LUI;
          default:      w_next_state = S_HALT;
        endcase
      end
      S_MEM_ADDR:  w_next_state = (bus.OP_i == 7'h03) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (bus.Mem_Ready_i)  w_next_state = S_MEM_WB;
        else if (w_stall_max) w_next_state = S_HALT;
      end
      S_MEM_WB:    w_next_state = S_FETCH;
      S_MEM_WRITE: begin
        if (bus.Mem_Ready_i)  w_next_state = S_FETCH;
        else if (w_stall_max) w_next_state = S_HALT;
      end
      S_EXEC_R:    w_next_state = S_ALU_WB;
      S_EXEC_I:    w_next_state = S_ALU_WB;
      S_ALU_WB:    w_next_state = S_FETCH;
      S_BEQ:       w_next_state = S_FETCH;
      S_JAL:       w_next_state = S_FETCH;
      S_LUI:       w_next_state = S_ALU_WB;
      S_HALT:      w_next_state = S_HALT;
      default:     w_next_state = S_HALT;
    endcase
  end

  // Datapath controls decoded from the state; reset kills every enable immediately.
  always_comb begin
    bus.Mem_Req_o    = 1'b0;
    bus.Mem_Write_o  = 1'b0;
    bus.I_or_D_o     = 1'b0;
    bus.IR_Write_o   = 1'b0;
    bus.PC_Write_o   = 1'b0;
    bus.PC_Src_o     = 1'b0;
    bus.ALU_Src_A_o  = 2'b00;
    bus.ALU_Src_B_o  = 2'b00;
    bus.ALU_Op_o     = 3'b000;
    bus.Result_Src_o = 2'b00;
    bus.Reg_Write_o  = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          bus.Mem_Req_o   = 1'b1;
          bus.ALU_Src_B_o = 2'b10;
          if (bus.Mem_Ready_i) begin
            bus.IR_Write_o   = 1'b1;
            bus.PC_Write_o   = 1'b1;
            bus.Result_Src_o = 2'b10;
          end
        end
        S_DECODE: begin
          bus.ALU_Src_A_o = 2'b01;
          bus.ALU_Src_B_o = 2'b01;
        end
        S_MEM_ADDR: begin
          bus.ALU_Src_A_o = 2'b10;
          bus.ALU_Src_B_o = 2'b01;
        end
        S_MEM_READ: begin
          bus.Mem_Req_o = 1'b1;
          bus.I_or_D_o  = 1'b1;
        end
        S_MEM_WB: begin
          bus.Reg_Write_o  = 1'b1;
          bus.Result_Src_o = 2'b01;
        end
        S_MEM_WRITE: begin
          bus.Mem_Req_o   = 1'b1;
          bus.Mem_Write_o = 1'b1;
          bus.I_or_D_o    = 1'b1;
        end
        S_EXEC_R: begin
          bus.ALU_Src_A_o = 2'b10;
          bus.ALU_Op_o    = 3'b010;
        end
        S_EXEC_I: begin
          bus.ALU_Src_A_o = 2'b10;
          bus.ALU_Src_B_o = 2'b01;
          bus.ALU_Op_o    = 3'b011;
        end
        S_ALU_WB: bus.Reg_Write_o = 1'b1;
        S_BEQ: begin
          bus.ALU_Src_A_o = 2'b10;
          bus.ALU_Op_o    = 3'b001;
          if (bus.Zero_i) begin
            bus.PC_Write_o = 1'b1;
            bus.PC_Src_o   = 1'b1;
          end
        end
        S_JAL: begin
          bus.ALU_Src_A_o  = 2'b01;
          bus.ALU_Src_B_o  = 2'b10;
          bus.Result_Src_o = 2'b10;
          bus.Reg_Write_o  = 1'b1;
          bus.PC_Write_o   = 1'b1;
          bus.PC_Src_o     = 1'b1;
        end
        S_LUI: begin
          bus.ALU_Src_B_o = 2'b01;
          bus.ALU_Op_o    = 3'b100;
        end
        default: ;
      endcase
    end
  end

  assign bus.Error_o = r_error;
  assign bus.State_o = r_state;

endmodule
